qspi_ram_loader: RTL and testbench
==================================

Name: qspi_ram_loader

Overview:
Boot-copy engine sitting directly upstream of the 32-bit dual-port on-chip RAM. On a start command it requests a byte read from the QSPI flash read engine. It packs the returned byte stream little-endian into 32-bit words and writes them through the RAM's second Avalon slave port. Reports busy/done/error and a running 32-bit checksum so the Nios boot code can validate the image.

Parameters:
RAM_AW, 13, RAM word-address width
RAM_DEPTH, 8192, RAM depth in 32-bit words
FLASH_AW, 24, flash byte-address width
TIMEOUT_CYCLES, 65535, max idle cycles between stream bytes before error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle command pulse, sampled only in IDLE
flash_addr  in  FLASH_AW  flash byte start address
ram_base  in  RAM_AW  first RAM word address
word_count  in  RAM_AW+1  number of 32-bit words to copy (0..RAM_DEPTH)
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse (success or error)
error  out  1  sticky until next accepted start
checksum  out  32  sum mod 2^32 of all words written this run
rd_req  out  1  flash read request, held until rd_ack
rd_addr  out  FLASH_AW  request byte address (= flash_addr)
rd_len  out  RAM_AW+3  request length in bytes (= word_count*4)
rd_ack  in  1  request accepted (transfer when rd_req & rd_ack)
rx_data  in  8  stream byte
rx_valid  in  1  stream byte valid
rx_ready  out  1  stream byte ready (beat when rx_valid & rx_ready)
ram_address  out  RAM_AW  RAM port-2 word address
ram_chipselect  out  1  RAM port-2 chipselect
ram_write  out  1  RAM port-2 write strobe
ram_byteenable  out  4  always 4'hF when writing
ram_writedata  out  32  packed word

Behaviour:
- Reset: all outputs 0, state IDLE, byte lane 0, timeout counter 0.
- FSM: IDLE -> REQ -> FILL -> DONE -> IDLE; CHECK is an internal single-cycle decision on start.
- IDLE: start latches inputs, clears checksum/error, sets busy next cycle. start while busy ignored.
- Bounds: word_count==0 -> DONE, error=0, no rd_req. ram_base+word_count > RAM_DEPTH (compare at RAM_AW+1 bits) -> DONE, error=1, no rd_req.
- REQ: rd_req=1 with stable rd_addr/rd_len until rd_ack cycle; next cycle FILL.
- FILL: rx_ready=1 continuously; no backpressure needed since RAM writes never stall. Byte k of a word goes to bits [8k+7:8k], first byte at bits [7:0].
- On 4th byte beat: word moves to a write-holding register. Next cycle: ram_chipselect=ram_write=1, byteenable=4'hF, address=ram_base+word_idx, one cycle only.
- Holding register decouples packing from writing, so a full-rate stream (rx_valid every cycle) loses no bytes.
- checksum += written word in the same cycle as the write strobe.
- Bytes beyond rd_len are not accepted: rx_ready=0 once the last byte is taken.
- Timeout: counter clears on every beat and increments in FILL otherwise. Reaching TIMEOUT_CYCLES -> error=1, DONE. Any partial word is discarded; completed writes stand.
- DONE: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- Latency: last byte beat at cycle T -> RAM write at T+1 -> done at T+2.
- checksum and error hold their values after done until the next accepted start.
- reset mid-run: immediate IDLE, all outputs zero, in-flight word dropped; the flash engine is reset by the same signal.

Decomposition:
- Shared package qspi_loader_pkg: FSM state enum, BYTES_PER_WORD=4, BYTEEN_ALL=4'hF.
- One sub-module, qspi_byte_packer: byte lane counter, little-endian shift/pack, word_valid pulse with word output.
- Top holds the FSM, address/word counters, timeout and checksum.

Test Plan:
- flash_addr=24'h100000, ram_base=0, word_count=2; bytes 01..08 back-to-back -> rd_len=8, writes 32'h04030201 @0 and 32'h08070605 @1, checksum=32'h0C0A0806, done at last-byte+2, error=0.
- word_count=0 -> done within 2 cycles of start, no rd_req, no RAM write, error=0.
- ram_base=8190, word_count=3 -> error=1, done pulse, rd_req never asserted.
- rd_ack delayed 5 cycles with rx_valid toggling 1/0 -> rd_req/rd_addr stable throughout, writes identical to the gapless case.
- TIMEOUT_CYCLES=16; stream stops after 6 bytes of 2 words -> one write (word 0), error=1 and done 16 cycles after the 6th byte.
- reset asserted mid-FILL -> next cycle busy=0, rx_ready=0, ram_write=0; a new start then runs a 1-word copy cleanly.

Source files
------------

// File: rtl/qspi_loader_pkg.sv
// Shared types and constants for the QSPI flash to on-chip RAM boot loader.
package qspi_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ   = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] BYTEEN_ALL     = 4'hF;

endpackage

// File: rtl/qspi_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; the finished word sits
// in a holding register with a one-cycle valid pulse.
module qspi_byte_packer
    import qspi_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        beat,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [23:0] acc;
    logic        last_lane;

    assign last_lane = (lane == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            lane       <= '0;
            acc        <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= beat && last_lane;
            if (beat) begin
                if (last_lane) begin
                    lane <= '0;
                    acc  <= '0;
                end else begin
                    lane <= lane + 2'd1;
                    acc  <= {data, acc[23:8]};
                end
            end
        end
    end

    // Holding register: frees the shifter to take the next byte immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (!clr && beat && last_lane) begin
            word <= {data, acc};
        end
    end

endmodule

// File: rtl/qspi_ram_loader.sv
// Boot-copy engine: requests a flash byte stream, packs it into words and
// writes them to RAM port 2 while keeping a running checksum.
module qspi_ram_loader
    import qspi_loader_pkg::*;
#(
    parameter int RAM_AW         = 13,
    parameter int RAM_DEPTH      = 8192,
    parameter int FLASH_AW       = 24,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [FLASH_AW-1:0] flash_addr,
    input  logic [RAM_AW-1:0]   ram_base,
    input  logic [RAM_AW:0]     word_count,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [31:0]         checksum,
    output logic                rd_req,
    output logic [FLASH_AW-1:0] rd_addr,
    output logic [RAM_AW+2:0]   rd_len,
    input  logic                rd_ack,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [RAM_AW-1:0]   ram_address,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [3:0]          ram_byteenable,
    output logic [31:0]         ram_writedata
);

    localparam int WW = RAM_AW + 1;
    localparam int LW = RAM_AW + 3;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WW-1:0] DEPTH_W  = WW'(RAM_DEPTH);
    // Fires so that DONE lands on the TIMEOUT_CYCLES-th cycle after the last beat.
    localparam logic [TW-1:0] TMO_FIRE = TW'(TIMEOUT_CYCLES - 2);

    state_t state, state_n;

    logic [FLASH_AW-1:0] faddr_r;
    logic [RAM_AW-1:0]   base_r;
    logic [WW-1:0]       wc_r;
    logic [LW-1:0]       len_r;
    logic [LW-1:0]       byte_cnt;
    logic [WW-1:0]       word_idx;
    logic [TW-1:0]       tmo_cnt;

    logic        beat;
    logic        wr_en;
    logic        last_word;
    logic        err_set;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic [WW-1:0] end_w;

    assign busy      = (state == S_CHECK) || (state == S_REQ) ||
                       (state == S_FILL);
    assign done      = (state == S_DONE);
    assign rd_req    = (state == S_REQ);
    assign rd_addr   = faddr_r;
    assign rd_len    = len_r;
    assign rx_ready  = (state == S_FILL) && (byte_cnt != len_r);
    assign beat      = rx_valid && rx_ready;
    assign wr_en     = pk_valid && (state == S_FILL);
    assign last_word = (word_idx == wc_r - WW'(1));
    assign end_w     = {1'b0, base_r} + wc_r;

    assign ram_chipselect = wr_en;
    assign ram_write      = wr_en;
    assign ram_byteenable = wr_en ? BYTEEN_ALL : 4'h0;
    assign ram_writedata  = wr_en ? pk_word : 32'h0;
    assign ram_address    = base_r + word_idx[RAM_AW-1:0];

    qspi_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clr        (state != S_FILL),
        .beat       (beat),
        .data       (rx_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_comb begin
        state_n = state;
        err_set = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (wc_r == '0) begin
                    state_n = S_DONE;
                end else if (end_w > DEPTH_W) begin
                    state_n = S_DONE;
                    err_set = 1'b1;
                end else begin
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (rd_ack) state_n = S_FILL;
            end
            S_FILL: begin
                if (wr_en && last_word) begin
                    state_n = S_DONE;
                end else if (!beat && tmo_cnt == TMO_FIRE) begin
                    state_n = S_DONE;
                    err_set = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            faddr_r  <= '0;
            base_r   <= '0;
            wc_r     <= '0;
            len_r    <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            tmo_cnt  <= '0;
            checksum <= '0;
            error    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && start) begin
                faddr_r  <= flash_addr;
                base_r   <= ram_base;
                wc_r     <= word_count;
                len_r    <= {word_count, 2'b00};
                byte_cnt <= '0;
                word_idx <= '0;
                checksum <= '0;
                error    <= 1'b0;
            end
            if (err_set) error <= 1'b1;
            if (beat) byte_cnt <= byte_cnt + LW'(1);
            if (wr_en) begin
                word_idx <= word_idx + WW'(1);
                checksum <= checksum + pk_word;
            end
            if (state == S_FILL && !beat) tmo_cnt <= tmo_cnt + TW'(1);
            else                          tmo_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_qspi_ram_loader.sv
// Randomised bench for qspi_ram_loader against a byte-stream reference model.
module tb_qspi_ram_loader;

    localparam int RAM_DEPTH = 8192;
    localparam int TMO       = 16;

    logic        clk = 1'b0;
    logic        reset, start, rd_ack, rx_valid;
    logic [23:0] flash_addr;
    logic [12:0] ram_base;
    logic [13:0] word_count;
    logic [7:0]  rx_data;
    logic        busy, done, error, rd_req, rx_ready;
    logic [31:0] checksum, ram_writedata;
    logic [23:0] rd_addr;
    logic [15:0] rd_len;
    logic [12:0] ram_address;
    logic        ram_chipselect, ram_write;
    logic [3:0]  ram_byteenable;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    qspi_ram_loader #(
        .RAM_AW(13), .RAM_DEPTH(RAM_DEPTH), .FLASH_AW(24),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .flash_addr(flash_addr), .ram_base(ram_base),
        .word_count(word_count), .busy(busy), .done(done),
        .error(error), .checksum(checksum), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observations of one run
    logic [7:0]  stream[$];
    int          beat_cyc[$];
    logic [12:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          sent, req_cycles, done_cnt, done_cyc, start_cyc, be_bad;
    bit          req_unstable, timed_out;
    logic        busy_after, err_at_done, busy_at_done, done_after, err_after;
    logic [23:0] req_addr0;
    logic [15:0] req_len0;
    logic [31:0] sum_at_done;

    // Reference model
    logic [12:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_wcyc[$];
    logic [31:0] exp_sum;

    task automatic fill_stream(input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
    endtask

    task automatic build_model(input logic [12:0] base, input int nw);
        logic [31:0] w;
        exp_addr.delete(); exp_data.delete(); exp_wcyc.delete();
        exp_sum = 32'h0;
        for (int i = 0; i < nw; i++) begin
            w = 32'(stream[4*i]) + (32'(stream[4*i+1]) << 8) +
                (32'(stream[4*i+2]) << 16) + (32'(stream[4*i+3]) << 24);
            exp_addr.push_back(13'(int'(base) + i));
            exp_data.push_back(w);
            exp_wcyc.push_back(beat_cyc[4*i+3] + 1);
            exp_sum = exp_sum + w;
        end
    endtask

    task automatic run(input logic [23:0] fa, input logic [12:0] base,
                       input logic [13:0] wc, input int ack_dly,
                       input bit gappy, input bit spurious, input int abort_at);
        bit tog;
        tog = 1'b0;
        beat_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        sent = 0; req_cycles = 0; done_cnt = 0; done_cyc = -1; be_bad = 0;
        req_unstable = 0; timed_out = 1; busy_after = 1'b0;
        flash_addr = fa; ram_base = base; word_count = wc;
        start = 1'b1; start_cyc = cyc;
        for (int t = 1; t <= 400; t++) begin
            @(posedge clk); #1;
            start = 1'b0; rd_ack = 1'b0; rx_valid = 1'b0;
            if (t == 1) busy_after = busy;
            if (ram_write) begin
                wr_addr.push_back(ram_address);
                wr_data.push_back(ram_writedata);
                wr_cyc.push_back(cyc);
                if (ram_byteenable !== 4'hF || ram_chipselect !== 1'b1) be_bad++;
            end
            if (rd_req) begin
                if (req_cycles == 0) begin
                    req_addr0 = rd_addr; req_len0 = rd_len;
                end else if (rd_addr !== req_addr0 || rd_len !== req_len0) begin
                    req_unstable = 1;
                end
                req_cycles++;
                rd_ack = (req_cycles > ack_dly);
            end
            if (done) begin
                done_cnt++; done_cyc = cyc; err_at_done = error;
                busy_at_done = busy; sum_at_done = checksum; timed_out = 0;
                break;
            end
            if (abort_at >= 0 && sent == abort_at) begin
                reset = 1'b1; timed_out = 0;
                break;
            end
            if (spurious && t == 2) begin
                start = 1'b1; ram_base = ~base; word_count = 14'd0;
            end
            if (sent < stream.size()) begin
                rx_data = stream[sent];
                rx_valid = gappy ? tog : 1'b1;
            end
            tog = ~tog;
            if (rx_valid && rx_ready) begin
                beat_cyc.push_back(cyc);
                sent++;
            end
        end
        if (done_cnt > 0) begin
            @(posedge clk); #1;
            done_after = done; err_after = error;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rd_ack = 1'b0; rx_valid = 1'b0;
        rx_data = 8'h0; flash_addr = '0; ram_base = '0; word_count = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, error, rd_req, rx_ready, ram_chipselect, ram_write} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy, done, error, rd_req, rx_ready, ram_chipselect, ram_write});
        end
        n_checks++;
        if ({checksum, ram_writedata, ram_byteenable, ram_address, rd_addr, rd_len} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got csum=%h wd=%h be=%h ra=%h fa=%h len=%h want all 0",
                     checksum, ram_writedata, ram_byteenable, ram_address, rd_addr, rd_len);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        stream.delete();
        for (int i = 1; i <= 8; i++) stream.push_back(8'(i));
        run(24'h100000, 13'd0, 14'd2, 0, 1'b0, 1'b0, -1);
        build_model(13'd0, 2);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL basic_budget: no done within bound"); end
        n_checks++;
        if (req_len0 !== 16'd8 || req_addr0 !== 24'h100000) begin
            n_fail++;
            $display("FAIL basic_req: got len=%0d addr=%h want 8 100000", req_len0, req_addr0);
        end
        n_checks++;
        if (wr_data.size() != 2) begin
            n_fail++; $display("FAIL basic_nwr: got %0d want 2", wr_data.size());
        end
        foreach (exp_data[i]) begin
            n_checks++;
            if (i >= wr_data.size() || wr_data[i] !== exp_data[i] ||
                wr_addr[i] !== exp_addr[i] || wr_cyc[i] != exp_wcyc[i]) begin
                n_fail++;
                $display("FAIL basic_wr%0d: got %h@%0d want %h@%0d", i,
                         (i < wr_data.size()) ? wr_data[i] : 32'hx,
                         (i < wr_addr.size()) ? wr_addr[i] : 13'hx,
                         exp_data[i], exp_addr[i]);
            end
        end
        n_checks++;
        if (wr_data.size() == 2 && (wr_data[0] !== 32'h04030201 || wr_data[1] !== 32'h08070605)) begin
            n_fail++;
            $display("FAIL basic_words: got %h %h want 04030201 08070605", wr_data[0], wr_data[1]);
        end
        n_checks++;
        if (sum_at_done !== 32'h0C0A0806) begin
            n_fail++; $display("FAIL basic_csum: got %h want 0c0a0806", sum_at_done);
        end
        n_checks++;
        if (beat_cyc.size() != 8 || done_cyc != beat_cyc[7] + 2) begin
            n_fail++;
            $display("FAIL basic_latency: got done@%0d want %0d", done_cyc,
                     (beat_cyc.size() == 8) ? beat_cyc[7] + 2 : -1);
        end
        n_checks++;
        if ({err_at_done, busy_at_done, done_after, be_bad != 0} !== 4'b0) begin
            n_fail++;
            $display("FAIL basic_flags: got err=%b busy=%b done_next=%b be_bad=%0d want 0 0 0 0",
                     err_at_done, busy_at_done, done_after, be_bad);
        end
    endtask

    task automatic test_zero_count();
        stream.delete();
        run(24'($urandom), 13'($urandom), 14'd0, 0, 1'b0, 1'b0, -1);
        n_checks++;
        if (timed_out || done_cyc - start_cyc > 2) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d cycles want <= 2", done_cyc - start_cyc);
        end
        n_checks++;
        if (req_cycles != 0 || wr_data.size() != 0 || err_at_done !== 1'b0 || busy_after !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_effects: got req=%0d wr=%0d err=%b busy=%b want 0 0 0 1",
                     req_cycles, wr_data.size(), err_at_done, busy_after);
        end
    endtask

    task automatic test_bounds();
        fill_stream(12);
        run(24'h000040, 13'd8190, 14'd3, 0, 1'b0, 1'b0, -1);
        n_checks++;
        if (timed_out || err_at_done !== 1'b1 || err_after !== 1'b1) begin
            n_fail++;
            $display("FAIL bounds_err: got err=%b hold=%b want 1 1", err_at_done, err_after);
        end
        n_checks++;
        if (req_cycles != 0 || wr_data.size() != 0 || sent != 0) begin
            n_fail++;
            $display("FAIL bounds_quiet: got req=%0d wr=%0d bytes=%0d want 0 0 0",
                     req_cycles, wr_data.size(), sent);
        end
        fill_stream(12);
        run(24'h000080, 13'd8189, 14'd3, 1, 1'b0, 1'b0, -1);
        build_model(13'd8189, 3);
        n_checks++;
        if (timed_out || err_at_done !== 1'b0 || wr_data.size() != 3) begin
            n_fail++;
            $display("FAIL edge_run: got err=%b wr=%0d want 0 3", err_at_done, wr_data.size());
        end
        foreach (exp_data[i]) begin
            n_checks++;
            if (i >= wr_data.size() || wr_data[i] !== exp_data[i] || wr_addr[i] !== exp_addr[i]) begin
                n_fail++;
                $display("FAIL edge_wr%0d: got %h@%0d want %h@%0d", i,
                         (i < wr_data.size()) ? wr_data[i] : 32'hx,
                         (i < wr_addr.size()) ? wr_addr[i] : 13'hx,
                         exp_data[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_ack_delay();
        logic [23:0] fa;
        fa = 24'($urandom);
        fill_stream(12);
        run(fa, 13'd100, 14'd3, 5, 1'b1, 1'b0, -1);
        build_model(13'd100, 3);
        n_checks++;
        if (timed_out || req_cycles != 6 || req_unstable || req_addr0 !== fa || req_len0 !== 16'd12) begin
            n_fail++;
            $display("FAIL ack_req: got held=%0d unstable=%0d addr=%h len=%0d want 6 0 %h 12",
                     req_cycles, req_unstable, req_addr0, req_len0, fa);
        end
        n_checks++;
        if (wr_data.size() != 3 || sum_at_done !== exp_sum || done_cyc != beat_cyc[11] + 2) begin
            n_fail++;
            $display("FAIL ack_result: got wr=%0d csum=%h done@%0d want 3 %h %0d",
                     wr_data.size(), sum_at_done, done_cyc, exp_sum, beat_cyc[11] + 2);
        end
        foreach (exp_data[i]) begin
            n_checks++;
            if (i >= wr_data.size() || wr_data[i] !== exp_data[i] ||
                wr_addr[i] !== exp_addr[i] || wr_cyc[i] != exp_wcyc[i]) begin
                n_fail++;
                $display("FAIL ack_wr%0d: got %h want %h", i,
                         (i < wr_data.size()) ? wr_data[i] : 32'hx, exp_data[i]);
            end
        end
    endtask

    task automatic test_timeout();
        fill_stream(6);
        run(24'h000200, 13'd40, 14'd2, 0, 1'b0, 1'b0, -1);
        build_model(13'd40, 1);
        n_checks++;
        if (timed_out || err_at_done !== 1'b1 || sent != 6 || done_cyc != beat_cyc[5] + TMO) begin
            n_fail++;
            $display("FAIL tmo_done: got err=%b bytes=%0d done@%0d want 1 6 %0d",
                     err_at_done, sent, done_cyc, beat_cyc[5] + TMO);
        end
        n_checks++;
        if (wr_data.size() != 1 || wr_data[0] !== exp_data[0] || wr_addr[0] !== exp_addr[0] ||
            sum_at_done !== exp_sum) begin
            n_fail++;
            $display("FAIL tmo_writes: got n=%0d csum=%h want 1 %h",
                     wr_data.size(), sum_at_done, exp_sum);
        end
    endtask

    task automatic test_overrun();
        fill_stream(13);
        run(24'h000300, 13'd7, 14'd2, 2, 1'b0, 1'b0, -1);
        build_model(13'd7, 2);
        n_checks++;
        if (timed_out || sent != 8 || wr_data.size() != 2 || sum_at_done !== exp_sum) begin
            n_fail++;
            $display("FAIL overrun: got bytes=%0d wr=%0d csum=%h want 8 2 %h",
                     sent, wr_data.size(), sum_at_done, exp_sum);
        end
    endtask

    task automatic test_back_to_back();
        int wc, base;
        for (int r = 0; r < 5; r++) begin
            wc = $urandom_range(1, 5);
            base = $urandom_range(0, RAM_DEPTH - wc);
            fill_stream(4 * wc);
            run(24'($urandom), 13'(base), 14'(wc), $urandom_range(0, 3),
                1'($urandom), 1'b1, -1);
            build_model(13'(base), wc);
            n_checks++;
            if (timed_out || err_at_done !== 1'b0 || wr_data.size() != wc ||
                sum_at_done !== exp_sum || done_cyc != beat_cyc[4*wc-1] + 2) begin
                n_fail++;
                $display("FAIL b2b%0d: got err=%b wr=%0d csum=%h done@%0d want 0 %0d %h %0d",
                         r, err_at_done, wr_data.size(), sum_at_done, done_cyc,
                         wc, exp_sum, beat_cyc[4*wc-1] + 2);
            end
            foreach (exp_data[i]) begin
                n_checks++;
                if (i >= wr_data.size() || wr_data[i] !== exp_data[i] ||
                    wr_addr[i] !== exp_addr[i] || wr_cyc[i] != exp_wcyc[i]) begin
                    n_fail++;
                    $display("FAIL b2b%0d_wr%0d: got %h@%0d want %h@%0d", r, i,
                             (i < wr_data.size()) ? wr_data[i] : 32'hx,
                             (i < wr_addr.size()) ? wr_addr[i] : 13'hx,
                             exp_data[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_stream(16);
        run(24'h000400, 13'd20, 14'd4, 0, 1'b0, 1'b0, 6);
        @(posedge clk); #1;
        n_checks++;
        if ({busy, rx_ready, ram_write, done, error} !== 5'b0 || checksum !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got busy=%b rdy=%b wr=%b done=%b err=%b csum=%h want 0",
                     busy, rx_ready, ram_write, done, error, checksum);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        fill_stream(4);
        run(24'h000500, 13'd3, 14'd1, 0, 1'b0, 1'b0, -1);
        build_model(13'd3, 1);
        n_checks++;
        if (timed_out || err_at_done !== 1'b0 || wr_data.size() != 1 ||
            wr_data[0] !== exp_data[0] || wr_addr[0] !== exp_addr[0] || sum_at_done !== exp_sum) begin
            n_fail++;
            $display("FAIL rst_rerun: got err=%b wr=%0d csum=%h want 0 1 %h",
                     err_at_done, wr_data.size(), sum_at_done, exp_sum);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_bounds();
        test_ack_delay();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
